// File: rtl/hazard_forward_unit_if.sv
// Hazard/forwarding bundle between the core pipeline and the hazard unit.
// The pipeline (master) presents the ID-stage decode; the unit (slave) returns control and forwarding selects.
interface hazard_forward_unit_if #(
  parameter int REG_W = 4,
  parameter int CNT_W = 16
);
  logic [REG_W-1:0] ID_rn;
  logic [REG_W-1:0] ID_rm;
  logic [REG_W-1:0] ID_rd;
  logic             ID_use_rn;
  logic             ID_use_rm;
  logic             ID_use_rd;
  logic             ID_RF_enable;
  logic             ID_load_instr;
  logic             branch_taken;

  logic             LE;
  logic             SS;
  logic             IF_ID_flush;
  logic [1:0]       fwd_A;
  logic [1:0]       fwd_B;
  logic [1:0]       fwd_C;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  modport master (
    output ID_rn, ID_rm, ID_rd, ID_use_rn, ID_use_rm, ID_use_rd,
           ID_RF_enable, ID_load_instr, branch_taken,
    input  LE, SS, IF_ID_flush, fwd_A, fwd_B, fwd_C, stall_cnt, flush_cnt
  );

  modport slave (
    input  ID_rn, ID_rm, ID_rd, ID_use_rn, ID_use_rm, ID_use_rd,
           ID_RF_enable, ID_load_instr, branch_taken,
    output LE, SS, IF_ID_flush, fwd_A, fwd_B, fwd_C, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/hazard_forward_unit.sv
// Load-use stall, branch flush and ID-stage operand forwarding for the 5-stage core.
// A shadow EX/MEM/WB pipeline of destination/write/load flags drives all decisions.
module hazard_forward_unit #(
  parameter int REG_W = 4,
  parameter int CNT_W = 16
) (
  input logic                  clk,
  input logic                  R,
  hazard_forward_unit_if.slave bus
);

  localparam logic [REG_W-1:0] PC_REG = '1;

  logic [REG_W-1:0] ex_rd, mem_rd, wb_rd;
  logic             ex_wr, ex_ld, mem_wr, wb_wr;
  logic [CNT_W-1:0] stall_q, flush_q;
  logic             stall, flush;
  logic             ex_hit_a, ex_hit_b, ex_hit_c;

  function automatic logic hit(input logic use_x, input logic [REG_W-1:0] x,
                               input logic wr, input logic [REG_W-1:0] rd);
    return use_x && wr && (rd == x) && (x != PC_REG);
  endfunction

  // Nearest producer wins: EX, then MEM, then WB.
  function automatic logic [1:0] sel(input logic use_x, input logic [REG_W-1:0] x);
    logic [1:0] s;
    s = 2'b00;
    if (hit(use_x, x, ex_wr, ex_rd))        s = 2'b01;
    else if (hit(use_x, x, mem_wr, mem_rd)) s = 2'b10;
    else if (hit(use_x, x, wb_wr, wb_rd))   s = 2'b11;
    return s;
  endfunction

  assign ex_hit_a = hit(bus.ID_use_rn, bus.ID_rn, ex_wr, ex_rd);
  assign ex_hit_b = hit(bus.ID_use_rm, bus.ID_rm, ex_wr, ex_rd);
  assign ex_hit_c = hit(bus.ID_use_rd, bus.ID_rd, ex_wr, ex_rd);

  // Reset gating keeps outputs quiet even before the cleared flags settle.
  assign stall = !R && ex_ld && (ex_hit_a || ex_hit_b || ex_hit_c);
  assign flush = !R && bus.branch_taken && !stall;

  assign bus.LE          = !stall;
  assign bus.SS          = stall;
  assign bus.IF_ID_flush = flush;
  assign bus.fwd_A       = R ? 2'b00 : sel(bus.ID_use_rn, bus.ID_rn);
  assign bus.fwd_B       = R ? 2'b00 : sel(bus.ID_use_rm, bus.ID_rm);
  assign bus.fwd_C       = R ? 2'b00 : sel(bus.ID_use_rd, bus.ID_rd);
  assign bus.stall_cnt   = stall_q;
  assign bus.flush_cnt   = flush_q;

  // The injected NOP carries no write/load, so the stalled consumer sees the load in MEM next.
  always_ff @(posedge clk or posedge R) begin
    if (R) begin
      ex_rd  <= '0;
      ex_wr  <= 1'b0;
      ex_ld  <= 1'b0;
      mem_rd <= '0;
      mem_wr <= 1'b0;
      wb_rd  <= '0;
      wb_wr  <= 1'b0;
    end else begin
      ex_rd  <= bus.ID_rd;
      ex_wr  <= bus.ID_RF_enable & ~stall;
      ex_ld  <= bus.ID_load_instr & ~stall;
      mem_rd <= ex_rd;
      mem_wr <= ex_wr;
      wb_rd  <= mem_rd;
      wb_wr  <= mem_wr;
    end
  end

  always_ff @(posedge clk or posedge R) begin
    if (R) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if (stall && (stall_q != '1)) stall_q <= stall_q + CNT_W'(1);
      if (flush && (flush_q != '1)) flush_q <= flush_q + CNT_W'(1);
    end
  end

endmodule
